// File: rtl/output_stream_buffer.sv
// Two-slot ping-pong capture buffer that serializes each output vector as BUS_CH-channel beats.
// Optional macro OUTPUT_STREAM_RELU_EN clamps negative lanes to zero on the read path.
module output_stream_buffer #(
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int DATA_WIDTH         = 16,
  parameter int BUS_CH             = 4
) (
  input  logic                                     clk,
  input  logic                                     arst_n_in,
  input  logic                                     flush,
  input  logic                                     cap_valid,
  output logic                                     cap_ready,
  input  logic [OUTPUT_NB_CHANNELS*DATA_WIDTH-1:0] cap_data,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]     cap_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]    cap_y,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [BUS_CH*DATA_WIDTH-1:0]             out_data,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]     out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]    out_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]    out_ch,
  output logic                                     out_last,
  output logic                                     busy
);

  localparam int NB_BEATS = OUTPUT_NB_CHANNELS / BUS_CH;
  localparam int XW       = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW       = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW       = $clog2(OUTPUT_NB_CHANNELS);
  localparam int BW       = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
  localparam int VW       = OUTPUT_NB_CHANNELS * DATA_WIDTH;
  localparam int OW       = BUS_CH * DATA_WIDTH;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB_BEATS - 1);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_wrPtr;
  logic            r_rdPtr;
  logic [BW-1:0]   r_beat;
  logic [VW-1:0]   r_slotData [2];
  logic [XW-1:0]   r_slotX [2];
  logic [YW-1:0]   r_slotY [2];

  logic                  w_push;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_lastBeat;
  logic [OW-1:0]         w_beatData;
  logic [DATA_WIDTH-1:0] w_lane;

  assign w_lastBeat = (r_beat == LAST_BEAT);
  assign w_push     = cap_valid && cap_ready;
  assign w_accept   = out_valid && out_ready;
  assign w_pop      = w_accept && w_lastBeat;

  // Reset and flush both drop every stored vector; payload slots need no clearing
  always_ff @(posedge clk) begin
    if (!arst_n_in || flush) begin
      r_state <= EMPTY;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_beat  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
        r_beat  <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst_n_in && !flush && w_push) begin
      r_slotData[r_wrPtr] <= cap_data;
      r_slotX[r_wrPtr]    <= cap_x;
      r_slotY[r_wrPtr]    <= cap_y;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      EMPTY:   if (w_push) w_nextState = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_nextState = TWO;
        else if (w_pop && !w_push) w_nextState = EMPTY;
      end
      TWO:     if (w_pop) w_nextState = ONE;
      default: w_nextState = EMPTY;
    endcase
  end

  // Lane i of the current beat is channel beat*BUS_CH+i of the slot being drained
  always_comb begin
    w_beatData = '0;
    w_lane     = '0;
    for (int i = 0; i < BUS_CH; i++) begin
      w_lane = r_slotData[r_rdPtr][(int'(r_beat) * BUS_CH + i) * DATA_WIDTH +: DATA_WIDTH];
`ifdef OUTPUT_STREAM_RELU_EN
      if (w_lane[DATA_WIDTH-1]) w_lane = '0;
`endif
      w_beatData[i*DATA_WIDTH +: DATA_WIDTH] = w_lane;
    end
  end

  // Payload outputs read as zero whenever nothing is buffered
  always_comb begin
    cap_ready = (r_state != TWO);
    out_valid = (r_state != EMPTY);
    busy      = (r_state != EMPTY);
    out_last  = (r_state != EMPTY) && w_lastBeat;
    out_data  = '0;
    out_x     = '0;
    out_y     = '0;
    out_ch    = '0;
    if (r_state != EMPTY) begin
      out_data = w_beatData;
      out_x    = r_slotX[r_rdPtr];
      out_y    = r_slotY[r_rdPtr];
      out_ch   = CW'(int'(r_beat) * BUS_CH);
    end
  end

endmodule

// File: tb/tb_output_stream_buffer.sv
// Scoreboard bench for output_stream_buffer: the driver queues expected beats per accepted capture,
// an independent negedge monitor compares and retires them as the consumer accepts beats.
module tb_output_stream_buffer;

  localparam int W   = 128;
  localparam int H   = 128;
  localparam int NCH = 32;
  localparam int DW  = 16;
  localparam int BUS = 4;
  localparam int NB  = NCH / BUS;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int CW  = $clog2(NCH);
  localparam int VW  = NCH * DW;
  localparam int OW  = BUS * DW;

  typedef struct {
    logic [OW-1:0] data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] ch;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic          flush;
  logic          cap_valid;
  logic          cap_ready;
  logic [VW-1:0] cap_data;
  logic [XW-1:0] cap_x;
  logic [YW-1:0] cap_y;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [CW-1:0] out_ch;
  logic          out_last;
  logic          busy;

  beat_t expQ[$];
  int    checks = 0;
  int    errors = 0;
  bit    monEn  = 1'b0;

  always #5 clk = ~clk;

  output_stream_buffer #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(NCH),
    .DATA_WIDTH(DW), .BUS_CH(BUS)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .flush(flush),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_data(cap_data),
    .cap_x(cap_x), .cap_y(cap_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  // Number of vectors still held: a partially drained vector still occupies its slot
  function automatic int vecCount();
    return (expQ.size() + NB - 1) / NB;
  endfunction

  function automatic void pushVector(input logic [VW-1:0] d, input logic [XW-1:0] x,
                                     input logic [YW-1:0] y);
    beat_t         e;
    logic [DW-1:0] v;
    for (int b = 0; b < NB; b++) begin
      e.data = '0;
      for (int i = 0; i < BUS; i++) begin
        v = d[(b * BUS + i) * DW +: DW];
`ifdef OUTPUT_STREAM_RELU_EN
        if ($signed(v) < 0) v = '0;
`endif
        e.data[i*DW +: DW] = v;
      end
      e.x    = x;
      e.y    = y;
      e.ch   = CW'(b * BUS);
      e.last = (b == NB - 1);
      expQ.push_back(e);
    end
  endfunction

  function automatic void checkField(input string name, input logic [63:0] act,
                                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void checkOutput();
    bit expValid;
    expValid = (expQ.size() != 0);
    checkField("cap_ready", 64'(cap_ready), 64'(vecCount() < 2));
    checkField("out_valid", 64'(out_valid), 64'(expValid));
    checkField("busy", 64'(busy), 64'(expValid));
    if (expValid) begin
      checkField("out_data", 64'(out_data), 64'(expQ[0].data));
      checkField("out_x", 64'(out_x), 64'(expQ[0].x));
      checkField("out_y", 64'(out_y), 64'(expQ[0].y));
      checkField("out_ch", 64'(out_ch), 64'(expQ[0].ch));
      checkField("out_last", 64'(out_last), 64'(expQ[0].last));
      if (out_ready) void'(expQ.pop_front());
    end else begin
      checkField("idle_data", 64'(out_data), 64'd0);
      checkField("idle_x", 64'(out_x), 64'd0);
      checkField("idle_y", 64'(out_y), 64'd0);
      checkField("idle_ch", 64'(out_ch), 64'd0);
      checkField("idle_last", 64'(out_last), 64'd0);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (monEn) checkOutput();
    end
  end

  task automatic applyStimulus(input logic rstn, input logic fl, input logic cv,
                               input logic [VW-1:0] d, input logic [XW-1:0] x,
                               input logic [YW-1:0] y, input logic rdy);
    bit doPush;
    bit doClear;
    arst_n_in = rstn;
    flush     = fl;
    cap_valid = cv;
    cap_data  = d;
    cap_x     = x;
    cap_y     = y;
    out_ready = rdy;
    doPush    = rstn && !fl && cv && (vecCount() < 2);
    doClear   = !rstn || fl;
    @(posedge clk);
    #1;
    if (doClear) expQ.delete();
    else if (doPush) pushVector(d, x, y);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] r;
    for (int k = 0; k < VW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [VW-1:0] ramp;
  logic [VW-1:0] reluVec;
  logic [DW-1:0] reluPat [4];

  initial begin
    for (int c = 0; c < NCH; c++) ramp[c*DW +: DW] = DW'(c + 1);
    reluPat[0] = 16'hFFFB;
    reluPat[1] = 16'h0000;
    reluPat[2] = 16'h0007;
    reluPat[3] = 16'h8000;
    for (int c = 0; c < NCH; c++) reluVec[c*DW +: DW] = reluPat[c % 4];

    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    monEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);

    // Single vector streamed with the consumer always ready
    applyStimulus(1'b1, 1'b0, 1'b1, ramp, XW'(5), YW'(9), 1'b1);
    idle(NB + 2, 1'b1);

    // Alternating back-pressure
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(17), YW'(3), 1'b1);
    for (int k = 0; k < 2 * NB + 2; k++) idle(1, (k % 2) == 0);

    // Fill both slots, attempt a third capture, then drain in order
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(0), YW'(0), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(0), YW'(1), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(0), YW'(2), 1'b0);
    idle(2 * NB + 2, 1'b1);

    // Capture offered while full and the last beat of A leaves, then retried
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(1), YW'(0), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(1), YW'(1), 1'b0);
    idle(NB - 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(1), YW'(2), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(1), YW'(2), 1'b1);
    idle(2 * NB + 2, 1'b1);

    // Flush and then reset in the middle of a vector
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(7), YW'(7), 1'b1);
    idle(3, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, randVec(), XW'(8), YW'(8), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, randVec(), XW'(9), YW'(9), 1'b1);
    idle(3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, ramp, XW'(10), YW'(10), 1'b1);
    idle(NB + 2, 1'b1);

    // Negative and extreme channel values
    applyStimulus(1'b1, 1'b0, 1'b1, reluVec, XW'(127), YW'(127), 1'b1);
    idle(NB + 2, 1'b1);

    // Randomized traffic with occasional flushes and resets
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 1) == 1), randVec(), XW'($urandom), YW'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    idle(3 * NB, 1'b1);
    checkField("drained", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
